supernova_fetch_queue: RTL and testbench
========================================

// Module: supernova_fetch_queue
// PURPOSE
//  Instruction buffer between supernova_fetch and decode. Holds up to DEPTH fetch blocks of
//  FETCH_WIDTH instrs plus block PC and fault flag; presents remaining instrs of head block.
//  Decode consumes 0..FETCH_WIDTH instrs/cycle. A redirect (mispredict / STU SQUASH, L2_START)
//  empties the queue in one cycle. Decouples fetch backpressure from decode width.
// PARAMETERS
//  DEPTH        4   blocks held; power of 2, >=2
//  FETCH_WIDTH  4   instrs per block (from supernova_pkg)
//  ILEN         32  instr width in bits
//  ADDR_WIDTH   64  PC width (stu_pkg::ADDR_WIDTH)
// PORTS
//  clk               in   1                    clock
//  rst               in   1                    reset; one clock; reset is synchronous and active-high
//  enq_valid_in      in   1                    fetch block valid
//  enq_ready_out     out  1                    queue can accept a block
//  enq_instr_in      in   FETCH_WIDTH*ILEN     block instrs, slot i at [i*ILEN +: ILEN]
//  enq_pc_in         in   ADDR_WIDTH           PC of slot 0
//  enq_fault_in      in   1                    iTLB/ICache error for this block
//  deq_instr_out     out  FETCH_WIDTH*ILEN     head instrs, realigned so slot 0 = next unconsumed
//  deq_pc_out        out  ADDR_WIDTH           PC of deq slot 0
//  deq_valid_out     out  FETCH_WIDTH          per-slot valid, thermometer from bit 0
//  deq_fault_out     out  1                    head block faulted
//  deq_take_in       in   $clog2(FETCH_WIDTH+1) instrs decode consumes this cycle
//  flush_in          in   1                    redirect; discard all contents
// BEHAVIOUR
//  - Reset: head/tail ptrs, count, offset = 0; enq_ready_out=0 while rst high, 1 the cycle after;
//    deq_valid_out=0, deq_fault_out=0, deq_pc_out=0, deq_instr_out=0.
//  - Enqueue fires when enq_valid_in & enq_ready_out; enq_ready_out = (count != DEPTH), from
//    registered count only (no comb path from deq_take_in or flush_in).
//  - Latency: block enqueued at edge N is visible on deq_* in cycle N+1; no bypass when empty.
//  - Head view: offset (0..FETCH_WIDTH-1) = instrs already consumed from head block;
//    deq slot i = head.instr[offset+i]; deq_valid_out[i] = !empty & (offset+i < FETCH_WIDTH);
//    deq_pc_out = head.pc + 4*offset (ADDR_WIDTH, modulo wrap); zero fill unused slots.
//  - Fault block: deq_valid_out = 1 on slot 0 only, deq_fault_out=1; decode takes 1 to pop it.
//  - Consume: deq_take_in <= popcount(deq_valid_out) required (SVA assert; RTL clamps to it).
//    offset+take == avail_end -> pop head, offset<=0; else offset<=offset+take. take=0 holds.
//  - Simultaneous enq+pop: count unchanged, both ptrs advance; legal incl. when full
//    (ready was already low, so full+pop only frees a slot next cycle).
//  - Pointers wrap mod DEPTH; count width $clog2(DEPTH+1).
//  - flush_in: highest priority; next cycle count=0, offset=0, ptrs=0; same-cycle enq and
//    deq_take_in ignored; enq_ready_out=1 next cycle. Flush while empty is a no-op.
//  - rst mid-operation: identical to flush plus outputs to reset values.
//  - Storage regs are not reset (only valid state is); no X may reach deq_* when empty.
// STRUCTURE
//  - supernova_pkg: FETCH_WIDTH, ILEN, FQ_DEPTH; typedef fq_entry_t {instr[FETCH_WIDTH], pc,
//    fault}; typedef fq_ptr_t. stu_pkg::addr_t for PCs.
//  - Single module; storage as fq_entry_t array; realign mux as one always_comb. No sub-module.
// TESTING
//  1 Reset then enq pc=0x8000_0000, instrs {A,B,C,D}, take=4 -> next cycle valid=4'b1111,
//    pc=0x8000_0000; following cycle valid=0, count=0.
//  2 Same block, take=1 then take=2 -> valid 1111, then 0111 pc=0x8000_0004 slot0=B, then 0001
//    pc=0x8000_000C slot0=D; take=1 pops.
//  3 Enq 4 blocks, take=0 -> enq_ready_out=0 after 4th; enq_valid held high is not accepted;
//    take=4 on head -> ready=1 next cycle, 5th block accepted; order preserved across ptr wrap.
//  4 Full queue, offset=2, flush_in with enq_valid_in=1 and take=2 -> next cycle valid=0,
//    ready=1, count=0; flushed-cycle block absent; next enq appears with offset 0.
//  5 Enq fault block pc=0x1000 -> valid=4'b0001, fault=1; take=1 -> pops, next block shown.
//  6 Random enq/take/flush 10k cycles vs scoreboard model; assert take<=avail, no X on deq_*.

Source files
------------

// File: rtl/supernova_fetch_queue_pkg.sv
// Shared configuration and entry types for the supernova fetch queue.
// Holds default geometry, PC type and the layout of one buffered fetch block.
package supernova_fetch_queue_pkg;

    localparam int FQ_FETCH_WIDTH = 4;
    localparam int FQ_ILEN        = 32;
    localparam int FQ_DEPTH       = 4;
    localparam int FQ_ADDR_WIDTH  = 64;

    typedef logic [FQ_ADDR_WIDTH-1:0]         addr_t;
    typedef logic [$clog2(FQ_DEPTH)-1:0]      fq_ptr_t;
    typedef logic [$clog2(FQ_DEPTH+1)-1:0]    fq_cnt_t;

    typedef struct packed {
        logic [FQ_FETCH_WIDTH-1:0][FQ_ILEN-1:0] instr;
        addr_t                                  pc;
        logic                                   fault;
    } fq_entry_t;

endpackage

// File: rtl/supernova_fetch_queue_chk.sv
// Protocol checker for the fetch queue dequeue interface.
// Decode may never consume more instructions than the queue presents.
module supernova_fetch_queue_chk
    import supernova_fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = FQ_FETCH_WIDTH
) (
    input logic                             clk,
    input logic                             rst,
    input logic [$clog2(FETCH_WIDTH+1)-1:0] deq_take,
    input logic [FETCH_WIDTH-1:0]           deq_valid,
    input logic                             deq_fault
);

    take_le_avail: assert property (@(posedge clk) disable iff (rst)
        int'(deq_take) <= $countones(deq_valid))
        else $error("deq_take_in exceeds the presented instruction count");

    valid_thermometer: assert property (@(posedge clk) disable iff (rst)
        ((deq_valid + FETCH_WIDTH'(1)) & deq_valid) == '0)
        else $error("deq_valid_out is not a thermometer code");

    fault_single_slot: assert property (@(posedge clk) disable iff (rst)
        deq_fault |-> (deq_valid == FETCH_WIDTH'(1)))
        else $error("faulted head block presents more than one slot");

    no_unknown: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({deq_valid, deq_fault}))
        else $error("unknown value on dequeue control outputs");

endmodule

// File: rtl/supernova_fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH blocks of FETCH_WIDTH instrs, head block
// presented realigned to the next unconsumed instruction, single-cycle flush.
module supernova_fetch_queue
    import supernova_fetch_queue_pkg::*;
#(
    parameter int DEPTH       = FQ_DEPTH,
    parameter int FETCH_WIDTH = FQ_FETCH_WIDTH,
    parameter int ILEN        = FQ_ILEN,
    parameter int ADDR_WIDTH  = FQ_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enq_valid_in,
    output logic                             enq_ready_out,
    input  logic [FETCH_WIDTH*ILEN-1:0]      enq_instr_in,
    input  logic [ADDR_WIDTH-1:0]            enq_pc_in,
    input  logic                             enq_fault_in,
    output logic [FETCH_WIDTH*ILEN-1:0]      deq_instr_out,
    output logic [ADDR_WIDTH-1:0]            deq_pc_out,
    output logic [FETCH_WIDTH-1:0]           deq_valid_out,
    output logic                             deq_fault_out,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] deq_take_in,
    input  logic                             flush_in
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int TAKE_W = $clog2(FETCH_WIDTH+1);
    localparam int OFF_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int IDX_W  = OFF_W + 1;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][ILEN-1:0] instr;
        logic [ADDR_WIDTH-1:0]            pc;
        logic                             fault;
    } entry_t;

    entry_t                           mem_r [DEPTH];
    logic [PTR_W-1:0]                 head_r;
    logic [PTR_W-1:0]                 tail_r;
    logic [CNT_W-1:0]                 count_r;
    logic [OFF_W-1:0]                 offset_r;
    logic                             ready_r;
    logic [FETCH_WIDTH-1:0][ILEN-1:0] deq_instr_r;
    logic [ADDR_WIDTH-1:0]            deq_pc_r;
    logic [FETCH_WIDTH-1:0]           deq_valid_r;
    logic                             deq_fault_r;

    entry_t                           enq_entry_s;
    entry_t                           head_entry_s;
    entry_t                           nxt_entry_s;
    logic [TAKE_W-1:0]                avail_s;
    logic [TAKE_W-1:0]                avail_end_s;
    logic [TAKE_W-1:0]                take_s;
    logic [TAKE_W-1:0]                consumed_s;
    logic                             pop_s;
    logic                             fire_s;
    logic                             wr_s;
    logic [PTR_W-1:0]                 head_n_s;
    logic [PTR_W-1:0]                 tail_n_s;
    logic [CNT_W-1:0]                 count_n_s;
    logic [OFF_W-1:0]                 offset_n_s;
    logic [IDX_W-1:0]                 slot_idx_s;
    logic [FETCH_WIDTH-1:0][ILEN-1:0] view_instr_s;
    logic [ADDR_WIDTH-1:0]            view_pc_s;
    logic [FETCH_WIDTH-1:0]           view_valid_s;
    logic                             view_fault_s;

    // Pack the incoming fetch block into the storage layout.
    always_comb begin
        enq_entry_s       = '0;
        enq_entry_s.instr = enq_instr_in;
        enq_entry_s.pc    = enq_pc_in;
        enq_entry_s.fault = enq_fault_in;
    end

    // Consume bookkeeping: a faulted block ends after slot 0, otherwise after the last slot.
    always_comb begin
        head_entry_s = mem_r[head_r];
        avail_end_s  = head_entry_s.fault ? TAKE_W'(1) : TAKE_W'(FETCH_WIDTH);
        if (count_r == '0) begin
            avail_s = '0;
        end else begin
            avail_s = avail_end_s - TAKE_W'(offset_r);
        end
        take_s     = (deq_take_in > avail_s) ? avail_s : deq_take_in;
        consumed_s = TAKE_W'(offset_r) + take_s;
        pop_s      = (take_s != '0) && (consumed_s == avail_end_s);
        fire_s     = enq_valid_in && ready_r;
    end

    // Next pointer/count/offset state; flush discards the same-cycle enqueue and take.
    always_comb begin
        if (flush_in) begin
            head_n_s   = '0;
            tail_n_s   = '0;
            count_n_s  = '0;
            offset_n_s = '0;
            wr_s       = 1'b0;
        end else begin
            head_n_s   = head_r + PTR_W'(pop_s);
            tail_n_s   = tail_r + PTR_W'(fire_s);
            count_n_s  = count_r + CNT_W'(fire_s) - CNT_W'(pop_s);
            offset_n_s = pop_s ? '0 : OFF_W'(consumed_s);
            wr_s       = fire_s;
        end
    end

    // Realigned view of the next-cycle head block, so the dequeue outputs can be registered.
    always_comb begin
        // The head next cycle is the block being written only when it becomes the sole entry.
        nxt_entry_s  = (wr_s && (tail_r == head_n_s)) ? enq_entry_s : mem_r[head_n_s];
        view_instr_s = '0;
        view_pc_s    = '0;
        view_valid_s = '0;
        view_fault_s = 1'b0;
        slot_idx_s   = '0;
        if (count_n_s != '0) begin
            view_fault_s = nxt_entry_s.fault;
            view_pc_s    = nxt_entry_s.pc + ADDR_WIDTH'({offset_n_s, 2'b00});
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                slot_idx_s = {1'b0, offset_n_s} + IDX_W'(i);
                if (nxt_entry_s.fault ? (i == 0) : (slot_idx_s < IDX_W'(FETCH_WIDTH))) begin
                    view_valid_s[i] = 1'b1;
                    view_instr_s[i] = nxt_entry_s.instr[slot_idx_s[OFF_W-1:0]];
                end else begin
                    view_valid_s[i] = 1'b0;
                    view_instr_s[i] = '0;
                end
            end
        end else begin
            view_valid_s = '0;
        end
    end

    // Control state and registered dequeue view.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            offset_r    <= '0;
            ready_r     <= 1'b0;
            deq_instr_r <= '0;
            deq_pc_r    <= '0;
            deq_valid_r <= '0;
            deq_fault_r <= 1'b0;
        end else begin
            head_r      <= head_n_s;
            tail_r      <= tail_n_s;
            count_r     <= count_n_s;
            offset_r    <= offset_n_s;
            ready_r     <= (count_n_s != CNT_W'(DEPTH));
            deq_instr_r <= view_instr_s;
            deq_pc_r    <= view_pc_s;
            deq_valid_r <= view_valid_s;
            deq_fault_r <= view_fault_s;
        end
    end

    // Block storage carries no reset; only the pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_s) begin
            mem_r[tail_r] <= enq_entry_s;
        end
    end

    assign enq_ready_out = ready_r;
    assign deq_instr_out = deq_instr_r;
    assign deq_pc_out    = deq_pc_r;
    assign deq_valid_out = deq_valid_r;
    assign deq_fault_out = deq_fault_r;

endmodule

// File: tb/tb_supernova_fetch_queue.sv
// Scoreboard bench for supernova_fetch_queue: a block-level queue model predicts each
// cycle's dequeue view; a monitor compares it with the DUT one cycle at a time.
module tb_supernova_fetch_queue;

    localparam int FW    = 4;
    localparam int IL    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int TW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enq_valid_in = 1'b0;
    logic              enq_ready_out;
    logic [FW*IL-1:0]  enq_instr_in = '0;
    logic [AW-1:0]     enq_pc_in = '0;
    logic              enq_fault_in = 1'b0;
    logic [FW*IL-1:0]  deq_instr_out;
    logic [AW-1:0]     deq_pc_out;
    logic [FW-1:0]     deq_valid_out;
    logic              deq_fault_out;
    logic [TW-1:0]     deq_take_in = '0;
    logic              flush_in = 1'b0;

    typedef struct packed {
        logic [FW*IL-1:0] ins;
        logic [AW-1:0]    pc;
        logic             fault;
    } blk_t;

    typedef struct packed {
        logic [FW-1:0]    valid;
        logic [FW*IL-1:0] instr;
        logic [AW-1:0]    pc;
        logic             fault;
        logic             ready;
    } view_t;

    blk_t  mq[$];
    int    moff;
    bit    mready;
    view_t exp_q[$];
    int    checks;
    int    failures;

    supernova_fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ILEN(IL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .enq_valid_in(enq_valid_in), .enq_ready_out(enq_ready_out),
        .enq_instr_in(enq_instr_in), .enq_pc_in(enq_pc_in), .enq_fault_in(enq_fault_in),
        .deq_instr_out(deq_instr_out), .deq_pc_out(deq_pc_out), .deq_valid_out(deq_valid_out),
        .deq_fault_out(deq_fault_out), .deq_take_in(deq_take_in), .flush_in(flush_in)
    );

    supernova_fetch_queue_chk #(.FETCH_WIDTH(FW)) u_chk (
        .clk(clk), .rst(rst), .deq_take(deq_take_in), .deq_valid(deq_valid_out),
        .deq_fault(deq_fault_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_avail();
        if (mq.size() == 0) return 0;
        if (mq[0].fault) return 1;
        return FW - moff;
    endfunction

    function automatic view_t m_view();
        view_t v;
        v = '0;
        v.ready = mready;
        if (mq.size() != 0) begin
            v.fault = mq[0].fault;
            v.pc    = mq[0].pc + AW'(4 * moff);
            for (int i = 0; i < m_avail(); i++) begin
                v.valid[i] = 1'b1;
                v.instr[i*IL +: IL] = mq[0].ins[(moff+i)*IL +: IL];
            end
        end
        return v;
    endfunction

    task automatic m_update(input bit r, input bit ev, input blk_t b, input int tk, input bit fl);
        bit fire;
        int aend;
        fire = ev && mready;
        if (r || fl) begin
            mq.delete();
            moff   = 0;
            mready = !r;
        end else begin
            if (tk > 0) begin
                aend = mq[0].fault ? 1 : FW;
                if (moff + tk == aend) begin
                    void'(mq.pop_front());
                    moff = 0;
                end else begin
                    moff += tk;
                end
            end
            if (fire) mq.push_back(b);
            mready = (mq.size() != DEPTH);
        end
    endtask

    task automatic step(input bit r, input bit ev, input blk_t b, input int tk, input bit fl);
        @(negedge clk);
        rst          = r;
        enq_valid_in = ev;
        enq_instr_in = b.ins;
        enq_pc_in    = b.pc;
        enq_fault_in = b.fault;
        deq_take_in  = TW'(tk);
        flush_in     = fl;
        @(posedge clk);
        #1;
        m_update(r, ev, b, tk, fl);
        exp_q.push_back(m_view());
    endtask

    function automatic blk_t mk_blk(input logic [AW-1:0] pc, input logic [IL-1:0] base, input logic f);
        blk_t b;
        b.pc    = pc;
        b.fault = f;
        for (int i = 0; i < FW; i++) b.ins[i*IL +: IL] = base + IL'(i);
        return b;
    endfunction

    function automatic blk_t rnd_blk();
        blk_t b;
        for (int i = 0; i < FW; i++) b.ins[i*IL +: IL] = $urandom;
        b.pc    = ($urandom_range(15, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
        b.fault = ($urandom_range(9, 0) == 0);
        return b;
    endfunction

    // Monitor: compares every predicted cycle view against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                view_t e;
                e = exp_q.pop_front();
                chk("sb_valid", deq_valid_out, e.valid);
                chk("sb_instr", deq_instr_out, e.instr);
                chk("sb_pc",    deq_pc_out,    e.pc);
                chk("sb_fault", deq_fault_out, e.fault);
                chk("sb_ready", enq_ready_out, e.ready);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        blk_t z, b1, b5, b6, fb;
        int   tk;
        bit   r, fl, ev;
        z  = '0;
        b1 = mk_blk(64'h8000_0000, 32'h1000_0000, 1'b0);
        b5 = mk_blk(64'h0000_5000, 32'h5000_0000, 1'b0);
        b6 = mk_blk(64'h0000_6000, 32'h6000_0000, 1'b0);
        fb = mk_blk(64'h0000_1000, 32'hF000_0000, 1'b1);
        checks = 0;
        failures = 0;
        mready = 1'b0;
        moff = 0;

        // Reset
        step(1, 0, z, 0, 0);
        step(1, 1, b1, 0, 0);
        chk("rst_ready", enq_ready_out, 1'b0);
        chk("rst_valid", deq_valid_out, 4'b0000);
        chk("rst_pc", deq_pc_out, 64'h0);
        step(0, 0, z, 0, 0);
        chk("rst_ready_after", enq_ready_out, 1'b1);

        // 1: full-width consume
        step(0, 1, b1, 0, 0);
        chk("t1_valid", deq_valid_out, 4'b1111);
        chk("t1_pc", deq_pc_out, 64'h8000_0000);
        step(0, 0, z, 4, 0);
        chk("t1_empty", deq_valid_out, 4'b0000);

        // 2: partial consumes realign the head
        step(0, 1, b1, 0, 0);
        step(0, 0, z, 1, 0);
        chk("t2_valid1", deq_valid_out, 4'b0111);
        chk("t2_pc1", deq_pc_out, 64'h8000_0004);
        chk("t2_slot0_b", deq_instr_out[IL-1:0], 32'h1000_0001);
        step(0, 0, z, 2, 0);
        chk("t2_valid2", deq_valid_out, 4'b0001);
        chk("t2_pc2", deq_pc_out, 64'h8000_000C);
        chk("t2_slot0_d", deq_instr_out[IL-1:0], 32'h1000_0003);
        step(0, 0, z, 1, 0);
        chk("t2_pop", deq_valid_out, 4'b0000);

        // 3: fill, backpressure, wrap
        for (int k = 0; k < 4; k++) step(0, 1, mk_blk(64'h2000 + 64'(k) * 64'h100, 32'h3000_0000 + IL'(k) * 32'h10, 1'b0), 0, 0);
        chk("t3_full_ready", enq_ready_out, 1'b0);
        step(0, 1, b5, 0, 0);
        chk("t3_held_ready", enq_ready_out, 1'b0);
        step(0, 1, b5, 4, 0);
        chk("t3_freed_ready", enq_ready_out, 1'b1);
        chk("t3_head_pc", deq_pc_out, 64'h2100);
        step(0, 1, b5, 0, 0);
        chk("t3_refull_ready", enq_ready_out, 1'b0);
        for (int k = 0; k < 3; k++) step(0, 0, z, 4, 0);
        chk("t3_wrap_order", deq_pc_out, 64'h5000);
        step(0, 0, z, 4, 0);

        // 4: flush beats same-cycle enqueue and take
        for (int k = 0; k < 4; k++) step(0, 1, mk_blk(64'h4000 + 64'(k) * 64'h40, 32'h4000_0000 + IL'(k) * 32'h10, 1'b0), 0, 0);
        step(0, 0, z, 2, 0);
        chk("t4_offset_pc", deq_pc_out, 64'h4008);
        step(0, 1, b6, 2, 1);
        chk("t4_flush_valid", deq_valid_out, 4'b0000);
        chk("t4_flush_ready", enq_ready_out, 1'b1);
        step(0, 1, b6, 0, 0);
        chk("t4_after_valid", deq_valid_out, 4'b1111);
        chk("t4_after_pc", deq_pc_out, 64'h6000);
        step(0, 0, z, 4, 0);

        // 5: fault block
        step(0, 1, fb, 0, 0);
        chk("t5_fault_valid", deq_valid_out, 4'b0001);
        chk("t5_fault_flag", deq_fault_out, 1'b1);
        step(0, 1, b1, 0, 0);
        step(0, 0, z, 1, 0);
        chk("t5_next_valid", deq_valid_out, 4'b1111);
        chk("t5_next_fault", deq_fault_out, 1'b0);
        chk("t5_next_pc", deq_pc_out, 64'h8000_0000);
        step(0, 0, z, 4, 0);

        // Reset in the middle of operation
        step(0, 1, b1, 0, 0);
        step(1, 1, b5, 0, 0);
        chk("mrst_ready", enq_ready_out, 1'b0);
        chk("mrst_valid", deq_valid_out, 4'b0000);
        step(0, 0, z, 0, 0);

        // 6: random traffic
        for (int n = 0; n < 10000; n++) begin
            r  = ($urandom_range(999, 0) == 0);
            fl = ($urandom_range(99, 0) < 3);
            ev = ($urandom_range(9, 0) < 6);
            tk = $urandom_range(m_avail(), 0);
            step(r, ev, rnd_blk(), tk, fl);
        end
        step(0, 0, z, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
